// File: rtl/l2spm_rr_arbiter.sv
// Round-robin arbiter sharing the single-ported L2 scratchpad SRAM among bus masters.
// Define L2SPM_ARB_RANGE_CHECK_EN to reject out-of-range addresses with err_o.
module l2spm_rr_arbiter #(
  parameter int unsigned          NumReq       = 4,
  parameter int unsigned          AddrWidth    = 64,
  parameter int unsigned          DataWidth    = 64,
  parameter int unsigned          MemAddrWidth = 13,
  parameter logic [AddrWidth-1:0] BaseAddr     = 'h1C00_0000,
  parameter logic [AddrWidth-1:0] Length       = 'h10000
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumReq-1:0]                     req_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]      addr_i,
  input  logic [NumReq-1:0]                     we_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]    be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]      wdata_i,
  output logic [NumReq-1:0]                     gnt_o,
  output logic [NumReq-1:0]                     rvalid_o,
  output logic [DataWidth-1:0]                  rdata_o,
  output logic                                  err_o,
  output logic                                  mem_req_o,
  output logic                                  mem_we_o,
  output logic [MemAddrWidth-1:0]               mem_addr_o,
  output logic [DataWidth/8-1:0]                mem_be_o,
  output logic [DataWidth-1:0]                  mem_wdata_o,
  input  logic [DataWidth-1:0]                  mem_rdata_i
);

  localparam int unsigned PtrWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned OffWidth = $clog2(DataWidth / 8);

  logic [PtrWidth-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PtrWidth-1:0]  win;
  logic                 found;
  logic                 grant;
  logic                 in_range;
  logic [AddrWidth-1:0] win_addr;
  logic [AddrWidth-1:0] offset;
  logic                 unused_offset;
  int unsigned          cand;

  logic                 rsp_valid_q;
  logic [PtrWidth-1:0]  rsp_idx_q;
  logic                 rsp_err_q;
  logic                 rsp_we_q;

  // First requester at or above rr_ptr (modulo NumReq) wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = (32'(rr_ptr_q) + i) % NumReq;
      if (!found && req_i[PtrWidth'(cand)]) begin
        found = 1'b1;
        win   = PtrWidth'(cand);
      end
    end
  end

  assign grant    = found & rst_ni;
  assign win_addr = addr_i[win];
  assign offset   = win_addr - BaseAddr;
  assign unused_offset = ^offset;

`ifdef L2SPM_ARB_RANGE_CHECK_EN
  assign in_range = (win_addr >= BaseAddr) && (offset < Length);
`else
  assign in_range = 1'b1;
`endif

  always_comb begin
    gnt_o      = '0;
    gnt_o[win] = grant;
  end

  assign mem_req_o   = grant & in_range;
  assign mem_we_o    = we_i[win];
  assign mem_addr_o  = offset[OffWidth +: MemAddrWidth];
  assign mem_be_o    = be_i[win];
  assign mem_wdata_o = wdata_i[win];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (win == PtrWidth'(NumReq - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= grant;
      if (grant) begin
        rsp_idx_q <= win;
        rsp_err_q <= ~in_range;
        rsp_we_q  <= we_i[win];
      end
    end
  end

  always_comb begin
    rvalid_o            = '0;
    rvalid_o[rsp_idx_q] = rsp_valid_q;
  end

  assign rdata_o = (rsp_valid_q && !rsp_we_q && !rsp_err_q) ? mem_rdata_i : '0;

`ifdef L2SPM_ARB_RANGE_CHECK_EN
  assign err_o = rsp_valid_q & rsp_err_q;
`else
  assign err_o = 1'b0;
`endif

`ifndef SYNTHESIS
  // A pending request must be held until it is granted.
  for (genvar g = 0; g < NumReq; g++) begin : gen_req_hold_chk
    req_held_until_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_i[g] && !gnt_o[g]) |=> req_i[g]);
  end
`endif

endmodule

// File: tb/tb_l2spm_rr_arbiter.sv
// Randomized self-checking bench for l2spm_rr_arbiter with a queue-free behavioural model
// and an SRAM model; honours L2SPM_ARB_RANGE_CHECK_EN.
module tb_l2spm_rr_arbiter;

  localparam int unsigned NumReq       = 4;
  localparam int unsigned AddrWidth    = 64;
  localparam int unsigned DataWidth    = 64;
  localparam int unsigned MemAddrWidth = 13;
  localparam logic [63:0] BaseAddr     = 64'h1C00_0000;
  localparam logic [63:0] Length       = 64'h10000;
  localparam int unsigned Words        = 8192;

  logic                               clk_i = 1'b0;
  logic                               rst_ni;
  logic [NumReq-1:0]                  req_i;
  logic [NumReq-1:0][AddrWidth-1:0]   addr_i;
  logic [NumReq-1:0]                  we_i;
  logic [NumReq-1:0][DataWidth/8-1:0] be_i;
  logic [NumReq-1:0][DataWidth-1:0]   wdata_i;
  logic [NumReq-1:0]                  gnt_o;
  logic [NumReq-1:0]                  rvalid_o;
  logic [DataWidth-1:0]               rdata_o;
  logic                               err_o;
  logic                               mem_req_o;
  logic                               mem_we_o;
  logic [MemAddrWidth-1:0]            mem_addr_o;
  logic [DataWidth/8-1:0]             mem_be_o;
  logic [DataWidth-1:0]               mem_wdata_o;
  logic [DataWidth-1:0]               mem_rdata_i;

  l2spm_rr_arbiter #(
    .NumReq       (NumReq),
    .AddrWidth    (AddrWidth),
    .DataWidth    (DataWidth),
    .MemAddrWidth (MemAddrWidth),
    .BaseAddr     (BaseAddr),
    .Length       (Length)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // SRAM macro: one-cycle read latency; garbage on the data bus when not reading.
  logic [63:0] sram [Words];
  always @(posedge clk_i) begin
    if (mem_req_o && !mem_we_o) mem_rdata_i <= sram[mem_addr_o];
    else                        mem_rdata_i <= {$urandom, $urandom};
    if (mem_req_o && mem_we_o) sram[mem_addr_o] <= merge(sram[mem_addr_o], mem_wdata_o, mem_be_o);
  end

  // Behavioural model: pointer, one pending response and an architectural memory image.
  logic [63:0]       ref_mem [Words];
  int                m_ptr;
  logic [NumReq-1:0] m_gnt;
  bit                pend_v, pend_err, pend_we;
  int                pend_idx;
  logic [63:0]       pend_rdata;
  int                c_win, c_j, c_word;
  bit                c_inr;
  logic [63:0]       c_addr;
  logic [3:0]        c_rvalid;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      m_ptr  = 0;
      pend_v = 0;
      m_gnt  = '0;
      chk("rst_gnt", gnt_o, 0);
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_rvalid", rvalid_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_rdata", rdata_o, 0);
    end else begin
      c_rvalid = '0;
      if (pend_v) c_rvalid[pend_idx] = 1'b1;
      chk("rvalid", rvalid_o, c_rvalid);
      chk("err", err_o, pend_v && pend_err);
      chk("rdata", rdata_o, (pend_v && !pend_we && !pend_err) ? pend_rdata : 64'd0);
      c_win = -1;
      for (int k = 0; k < NumReq; k++) begin
        c_j = (m_ptr + k) % NumReq;
        if (c_win < 0 && req_i[c_j]) c_win = c_j;
      end
      m_gnt = '0;
      if (c_win >= 0) m_gnt[c_win] = 1'b1;
      chk("gnt", gnt_o, m_gnt);
      pend_v = 0;
      if (c_win >= 0) begin
        c_addr = addr_i[c_win];
`ifdef L2SPM_ARB_RANGE_CHECK_EN
        c_inr = (c_addr >= BaseAddr) && (c_addr < BaseAddr + Length);
`else
        c_inr = 1'b1;
`endif
        c_word = int'(((c_addr - BaseAddr) >> 3) % 64'(Words));
        chk("mem_req", mem_req_o, c_inr);
        if (c_inr) begin
          chk("mem_addr", mem_addr_o, c_word);
          chk("mem_we", mem_we_o, we_i[c_win]);
          chk("mem_be", mem_be_o, be_i[c_win]);
          chk("mem_wdata", mem_wdata_o, wdata_i[c_win]);
        end
        pend_v     = 1;
        pend_idx   = c_win;
        pend_err   = !c_inr;
        pend_we    = we_i[c_win];
        pend_rdata = ref_mem[c_word];
        if (c_inr && we_i[c_win])
          ref_mem[c_word] = merge(ref_mem[c_word], wdata_i[c_win], be_i[c_win]);
        m_ptr = (c_win + 1) % NumReq;
      end else begin
        chk("mem_req_idle", mem_req_o, 0);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int j, input bit we, input logic [63:0] a, input logic [7:0] be,
                         input logic [63:0] d);
    req_i[j]   = 1'b1;
    we_i[j]    = we;
    addr_i[j]  = a;
    be_i[j]    = be;
    wdata_i[j] = d;
  endtask

  task automatic rand_req(input int j);
    logic [63:0] a;
    int sel;
    sel = $urandom_range(0, 15);
    if (sel == 0)      a = BaseAddr + Length + 64'(8 * $urandom_range(0, 255));
    else if (sel == 1) a = BaseAddr - 64'(8 * $urandom_range(1, 8));
    else               a = BaseAddr + 64'(8 * $urandom_range(0, 63)) + 64'($urandom_range(0, 7));
    set_req(j, 1'($urandom), a, 8'($urandom), {$urandom, $urandom});
  endtask

  // Retire granted requests until none are outstanding.
  task automatic drain();
    for (int i = 0; i < 16 && req_i != '0; i++) begin
      next_cycle();
      req_i = req_i & ~m_gnt;
    end
    chk("drain_done", req_i, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni  = 1'b0;
    req_i   = '0;
    we_i    = '0;
    addr_i  = '0;
    be_i    = '0;
    wdata_i = '0;
    for (int w = 0; w < Words; w++) begin
      sram[w]    = '0;
      ref_mem[w] = '0;
    end
    repeat (3) @(posedge clk_i);
    #1;

    // Full contention straight out of reset.
    for (int j = 0; j < NumReq; j++)
      set_req(j, 1'b0, BaseAddr + 64'(8 * $urandom_range(16, 79)), 8'hFF, 64'd0);
    rst_ni = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      chk("cont_gnt", gnt_o, onehot(c % 4));
      chk("cont_rvalid", rvalid_o, (c == 0) ? 4'b0000 : onehot((c - 1) % 4));
      next_cycle();
      for (int j = 0; j < NumReq; j++)
        if (m_gnt[j]) set_req(j, 1'b0, BaseAddr + 64'(8 * $urandom_range(16, 79)), 8'hFF, 64'd0);
    end

    // Reset in the cycle after a grant drops the response.
    @(negedge clk_i);
    chk("pre_rst_gnt", gnt_o, 4'b0001);
    next_cycle();
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_rvalid", rvalid_o, 0);
    chk("mid_rst_gnt", gnt_o, 0);
    next_cycle();
    next_cycle();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_gnt", gnt_o, 4'b0001);
    chk("post_rst_rvalid", rvalid_o, 0);
    drain();

    // Single write then read through requester 1.
    next_cycle();
    set_req(1, 1'b1, 64'h1C00_0008, 8'hFF, 64'hDEAD_BEEF_0000_0001);
    @(negedge clk_i);
    chk("wr_gnt", gnt_o, 4'b0010);
    chk("wr_addr", mem_addr_o, 1);
    next_cycle();
    set_req(1, 1'b0, 64'h1C00_0008, 8'hFF, 64'd0);
    @(negedge clk_i);
    chk("rd_gnt", gnt_o, 4'b0010);
    chk("rd_addr", mem_addr_o, 1);
    chk("wr_rvalid", rvalid_o, 4'b0010);
    chk("wr_rdata", rdata_o, 0);
    next_cycle();
    req_i = '0;
    @(negedge clk_i);
    chk("rd_rvalid", rvalid_o, 4'b0010);
    chk("rd_rdata", rdata_o, 64'hDEAD_BEEF_0000_0001);
    chk("rd_err", err_o, 0);

    // Pointer now at 2: requesters 0 and 3 -> 3 first, then 0.
    next_cycle();
    set_req(0, 1'b0, BaseAddr + 64'h100, 8'hFF, 64'd0);
    set_req(3, 1'b0, BaseAddr + 64'h108, 8'hFF, 64'd0);
    @(negedge clk_i);
    chk("skip_gnt3", gnt_o, 4'b1000);
    next_cycle();
    req_i[3] = 1'b0;
    @(negedge clk_i);
    chk("skip_gnt0", gnt_o, 4'b0001);
    chk("skip_rvalid3", rvalid_o, 4'b1000);
    next_cycle();
    req_i = '0;
    @(negedge clk_i);
    chk("skip_rvalid0", rvalid_o, 4'b0001);

    // Partial byte-enable write over word 0.
    next_cycle();
    set_req(2, 1'b1, BaseAddr, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk_i);
    chk("be_mem_be", mem_be_o, 8'h0F);
    next_cycle();
    set_req(2, 1'b0, BaseAddr, 8'hFF, 64'd0);
    next_cycle();
    req_i = '0;
    @(negedge clk_i);
    chk("be_rvalid", rvalid_o, 4'b0100);
    chk("be_rdata", rdata_o, 64'h0000_0000_FFFF_FFFF);

    // Just past the end of the scratchpad.
    next_cycle();
    set_req(0, 1'b0, 64'h1C01_0000, 8'hFF, 64'd0);
    @(negedge clk_i);
`ifdef L2SPM_ARB_RANGE_CHECK_EN
    chk("oor_mem_req", mem_req_o, 0);
`else
    chk("oor_mem_req", mem_req_o, 1);
    chk("oor_mem_addr", mem_addr_o, 0);
`endif
    next_cycle();
    req_i = '0;
    @(negedge clk_i);
    chk("oor_rvalid", rvalid_o, 4'b0001);
`ifdef L2SPM_ARB_RANGE_CHECK_EN
    chk("oor_err", err_o, 1);
    chk("oor_rdata", rdata_o, 0);
`else
    chk("oor_err", err_o, 0);
`endif

    // Randomized traffic with occasional resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_cycle();
      if (!rst_ni) rst_ni = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst_ni = 1'b0;
      for (int j = 0; j < NumReq; j++) begin
        if (req_i[j] && m_gnt[j]) req_i[j] = 1'b0;
        if (!req_i[j] && $urandom_range(0, 9) < 6) rand_req(j);
      end
    end
    if (!rst_ni) begin
      next_cycle();
      rst_ni = 1'b1;
    end
    drain();
    repeat (3) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
